// File: rtl/vending_machine_param.sv
// Parametrised vending controller: nickel/dime/quarter credit, vend, change and refund
// through a valid/ready dispenser handshake. Define VM_DIME_CHANGE_EN to pay change in dimes where possible.
module vending_machine_param #(
    parameter int PRICE_UNITS = 3,
    parameter int CREDIT_W    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                N,
    input  logic                D,
    input  logic                Q,
    input  logic                cancel,
    output logic                coin_accept_en,
    output logic                open,
    output logic [CREDIT_W-1:0] credit,
    output logic                change_valid,
    input  logic                change_ready,
    output logic                change_coin
);

    localparam int CW1 = CREDIT_W + 1;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_VEND    = 2'd1,
        ST_CHANGE  = 2'd2
    } state_t;

    localparam logic [CREDIT_W-1:0] CREDIT_ZERO = {CREDIT_W{1'b0}};
    localparam logic [CREDIT_W-1:0] ONE_UNIT    = CREDIT_W'(1);
    localparam logic [CREDIT_W-1:0] TWO_UNITS   = CREDIT_W'(2);
    localparam logic [CW1-1:0]      W_PRICE     = CW1'(PRICE_UNITS);

    // Value of the single coin credited this cycle; N outranks D outranks Q.
    function automatic logic [2:0] coin_value(input logic n, input logic d, input logic q);
        logic [2:0] v;
        if (n) begin
            v = 3'd1;
        end else if (d) begin
            v = 3'd2;
        end else if (q) begin
            v = 3'd5;
        end else begin
            v = 3'd0;
        end
        return v;
    endfunction

    state_t              r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic                r_open;
    logic                r_change_valid;
    logic                r_change_coin;
    logic                r_coin_accept_en;

    state_t              w_state_nx;
    logic [CREDIT_W-1:0] w_credit_nx;
    logic [CW1-1:0]      w_cn;
    logic [CREDIT_W-1:0] w_dec;
    logic [CREDIT_W-1:0] w_credit_chg;
    logic                w_dime_nx;

    // Credit arithmetic is one bit wider so the pre-subtraction sum never wraps.
    always_comb begin
        w_cn         = {1'b0, r_credit} + CW1'(coin_value(N, D, Q));
`ifdef VM_DIME_CHANGE_EN
        w_dec        = (r_credit >= TWO_UNITS) ? TWO_UNITS : ONE_UNIT;
`else
        w_dec        = ONE_UNIT;
`endif
        w_credit_chg = r_credit - w_dec;
    end

    // Next-state and next-credit decode.
    always_comb begin
        w_state_nx  = r_state;
        w_credit_nx = r_credit;
        case (r_state)
            ST_COLLECT: begin
                if (cancel && (w_cn != {CW1{1'b0}})) begin
                    w_state_nx  = ST_CHANGE;
                    w_credit_nx = CREDIT_W'(w_cn);
                end else if (w_cn >= W_PRICE) begin
                    w_state_nx  = ST_VEND;
                    w_credit_nx = CREDIT_W'(w_cn - W_PRICE);
                end else begin
                    w_state_nx  = ST_COLLECT;
                    w_credit_nx = CREDIT_W'(w_cn);
                end
            end
            ST_VEND: begin
                if (r_credit != CREDIT_ZERO) begin
                    w_state_nx = ST_CHANGE;
                end else begin
                    w_state_nx = ST_COLLECT;
                end
            end
            ST_CHANGE: begin
                if (change_ready) begin
                    w_credit_nx = w_credit_chg;
                    if (w_credit_chg == CREDIT_ZERO) begin
                        w_state_nx = ST_COLLECT;
                    end else begin
                        w_state_nx = ST_CHANGE;
                    end
                end else begin
                    w_state_nx  = ST_CHANGE;
                    w_credit_nx = r_credit;
                end
            end
            default: begin
                w_state_nx  = ST_COLLECT;
                w_credit_nx = CREDIT_ZERO;
            end
        endcase
    end

    // Coin type that will be offered once the next state is entered.
    always_comb begin
`ifdef VM_DIME_CHANGE_EN
        if (w_state_nx == ST_CHANGE) begin
            w_dime_nx = (w_credit_nx >= TWO_UNITS);
        end else begin
            w_dime_nx = 1'b0;
        end
`else
        w_dime_nx = 1'b0;
`endif
    end

    // State, credit and Moore outputs registered together from the next-state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_COLLECT;
            r_credit         <= CREDIT_ZERO;
            r_open           <= 1'b0;
            r_change_valid   <= 1'b0;
            r_change_coin    <= 1'b0;
            r_coin_accept_en <= 1'b1;
        end else begin
            r_state          <= w_state_nx;
            r_credit         <= w_credit_nx;
            r_open           <= (w_state_nx == ST_VEND);
            r_change_valid   <= (w_state_nx == ST_CHANGE);
            r_change_coin    <= w_dime_nx;
            r_coin_accept_en <= (w_state_nx == ST_COLLECT);
        end
    end

    assign coin_accept_en = r_coin_accept_en;
    assign open           = r_open;
    assign credit         = r_credit;
    assign change_valid   = r_change_valid;
    assign change_coin    = r_change_coin;

endmodule

// File: tb/tb_vending_machine_param.sv
// Scoreboard bench for vending_machine_param: a behavioural model pushes expected outputs per cycle,
// popped and compared after each clock edge. Honours VM_DIME_CHANGE_EN like the design.
module tb_vending_machine_param;

    localparam int PRICE = 3;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tb_n = 1'b0, tb_d = 1'b0, tb_q = 1'b0, tb_cancel = 1'b0;
    logic          tb_ready = 1'b0;
    logic          coin_accept_en, open, change_valid, change_coin;
    logic [CW-1:0] credit;

    vending_machine_param #(.PRICE_UNITS(PRICE), .CREDIT_W(CW)) dut (
        .clk(clk), .rst(rst), .N(tb_n), .D(tb_d), .Q(tb_q), .cancel(tb_cancel),
        .coin_accept_en(coin_accept_en), .open(open), .credit(credit),
        .change_valid(change_valid), .change_ready(tb_ready), .change_coin(change_coin)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          open;
        logic          cv;
        logic          coin;
        logic          acc;
        logic [CW-1:0] credit;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_state = 0;   // 0 collect, 1 vend, 2 change
    int   m_credit = 0;

`ifdef VM_DIME_CHANGE_EN
    localparam bit DIME_EN = 1'b1;
`else
    localparam bit DIME_EN = 1'b0;
`endif

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance the reference model by one edge and return the outputs it predicts.
    task automatic model_step(input logic n, d, q, c, rdy, r, output exp_t e);
        int v, cn, dec;
        if (r) begin
            m_state = 0; m_credit = 0;
        end else if (m_state == 0) begin
            v  = n ? 1 : (d ? 2 : (q ? 5 : 0));
            cn = m_credit + v;
            if (c && cn > 0) begin
                m_state = 2; m_credit = cn;
            end else if (cn >= PRICE) begin
                m_state = 1; m_credit = cn - PRICE;
            end else begin
                m_credit = cn;
            end
        end else if (m_state == 1) begin
            m_state = (m_credit > 0) ? 2 : 0;
        end else if (rdy) begin
            dec = (DIME_EN && m_credit >= 2) ? 2 : 1;
            m_credit -= dec;
            if (m_credit == 0) m_state = 0;
        end
        e.open   = (m_state == 1);
        e.cv     = (m_state == 2);
        e.coin   = (m_state == 2) && DIME_EN && (m_credit >= 2);
        e.acc    = (m_state == 0);
        e.credit = CW'(m_credit);
    endtask

    task automatic drive(input logic n, d, q, c, rdy, r);
        exp_t e, got;
        tb_n = n; tb_d = d; tb_q = q; tb_cancel = c; tb_ready = rdy; rst = r;
        model_step(n, d, q, c, rdy, r, e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check_val("open",   32'(open),           32'(got.open));
        check_val("cvalid", 32'(change_valid),   32'(got.cv));
        check_val("ccoin",  32'(change_coin),    32'(got.coin));
        check_val("accept", 32'(coin_accept_en), 32'(got.acc));
        check_val("credit", 32'(credit),         32'(got.credit));
    endtask

    task automatic idle(input int k, input logic rdy);
        for (int i = 0; i < k; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    initial begin
        #1;
        // reset, then exact price in nickels
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        check_val("rst_accept", 32'(coin_accept_en), 32'd1);
        check_val("rst_credit", 32'(credit), 32'd0);
        drive(1, 0, 0, 0, 0, 0);
        check_val("n1_credit", 32'(credit), 32'd1);
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        check_val("vend_open", 32'(open), 32'd1);
        check_val("vend_credit", 32'(credit), 32'd0);
        idle(3, 1'b1);
        check_val("no_change", 32'(change_valid), 32'd0);

        // quarter: vend then change of 2 units
        drive(0, 0, 1, 0, 1, 0);
        check_val("q_vend_credit", 32'(credit), 32'd2);
        idle(1, 1'b1);
        check_val("q_change_cv", 32'(change_valid), 32'd1);
        check_val("q_change_coin", 32'(change_coin), 32'(DIME_EN));
        idle(3, 1'b1);
        check_val("q_done_credit", 32'(credit), 32'd0);

        // dime then cancel: refund, no vend
        drive(0, 1, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 1, 0);
        check_val("cancel_credit", 32'(credit), 32'd2);
        check_val("cancel_open", 32'(open), 32'd0);
        idle(3, 1'b1);

        // reach CHANGE with credit 3, stall dispenser while feeding nickels
        drive(0, 1, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            drive(i[0], 0, 0, 0, 0, 0);
            check_val("hold_cv", 32'(change_valid), 32'd1);
            check_val("hold_credit", 32'(credit), 32'd3);
            check_val("hold_accept", 32'(coin_accept_en), 32'd0);
        end
        drive(0, 0, 0, 0, 1, 1);
        check_val("midrst_cv", 32'(change_valid), 32'd0);
        check_val("midrst_credit", 32'(credit), 32'd0);

        // simultaneous coins, then quarter with cancel
        drive(1, 1, 0, 0, 0, 0);
        check_val("nd_credit", 32'(credit), 32'd1);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 1, 1, 0, 0);
        check_val("qc_credit", 32'(credit), 32'd5);
        check_val("qc_cv", 32'(change_valid), 32'd1);
        idle(2, 1'b0);
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0);
        idle(6, 1'b1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
        end

        check_val("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
